// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and types for the fetch PC generation stage.
//   STALL_W    - width of the pipeline stall vector (bit 0 freezes the PC stage)
//   BR_WD      - width of a redirect bus {enable, target[31:0]}
//   STOP/NO_STOP - stall bit encodings
//   PEND_*     - 2-bit priority codes of a held redirect (higher value wins)
package pc_gen_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned BR_WD   = 33;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [1:0] PEND_BP    = 2'd0;
  localparam logic [1:0] PEND_BR    = 2'd1;
  localparam logic [1:0] PEND_FLUSH = 2'd2;

  typedef enum logic {
    StIdle,
    StHeld
  } pend_state_e;

  // A live candidate beats the held slot when nothing is held or when its
  // priority is at least that of the held one (ties go to the live value).
  function automatic logic live_beats_pend(input logic       live_v,
                                           input logic [1:0] live_kind,
                                           input logic       held,
                                           input logic [1:0] pend_kind);
    return live_v && (!held || (live_kind >= pend_kind));
  endfunction

endpackage

// File: rtl/pc_gen.sv
// pc_gen: program-counter generation at the head of the fetch pipeline.
// Picks the next fetch address from flush target, branch correction,
// predictor hit or PC+4, and holds redirects that arrive while stalled.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   stall      - stall vector, stall[0] freezes the PC register
//   flush      - exception/ERET flush, new_pc is its target
//   br_bus     - {br_e, br_target} execute-stage branch correction
//   bp_bus     - {bp_e, bp_target} branch-predictor hit
//   pc         - current fetch PC (inst-SRAM address, bpu.if_pc)
//   ce         - inst-SRAM enable
//   pend_v     - a held redirect is pending
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic [BR_WD-1:0]   br_bus,
  input  logic [BR_WD-1:0]   bp_bus,
  output logic [31:0]        pc,
  output logic               ce,
  output logic               pend_v
);

  logic        w_br_e;
  logic [31:0] w_br_tgt;
  logic        w_bp_e;
  logic [31:0] w_bp_tgt;
  logic        w_live_v;
  logic [1:0]  w_live_kind;
  logic [31:0] w_live_pc;
  logic        w_live_wins;
  logic [31:0] w_next_pc;
  logic        w_unused;

  pend_state_e r_state;
  logic [1:0]  r_pend_kind;
  logic [31:0] r_pend_pc;
  logic [31:0] r_pc;
  logic        r_ce;

  assign {w_br_e, w_br_tgt} = br_bus;
  assign {w_bp_e, w_bp_tgt} = bp_bus;

  // Upper stall bits belong to later pipeline stages.
  assign w_unused = ^stall[STALL_W-1:1];

  // Highest-priority live candidate this cycle.
  always_comb begin
    w_live_v    = 1'b1;
    w_live_kind = PEND_BP;
    w_live_pc   = w_bp_tgt;
    if (flush) begin
      w_live_kind = PEND_FLUSH;
      w_live_pc   = new_pc;
    end else if (w_br_e) begin
      w_live_kind = PEND_BR;
      w_live_pc   = w_br_tgt;
    end else if (!w_bp_e) begin
      w_live_v = 1'b0;
    end
  end

  assign w_live_wins = live_beats_pend(w_live_v, w_live_kind, r_state == StHeld, r_pend_kind);

  always_comb begin
    w_next_pc = r_pc + 32'd4;  // modulo 2^32, wraps silently
    if (w_live_wins) begin
      w_next_pc = w_live_pc;
    end else if (r_state == StHeld) begin
      w_next_pc = r_pend_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC - 32'd4;
      r_ce        <= 1'b0;
      r_state     <= StIdle;
      r_pend_kind <= PEND_BP;
      r_pend_pc   <= 32'd0;
    end else begin
      r_ce <= 1'b1;
      if (stall[0] == NO_STOP) begin
        // Slot is consumed or superseded by w_next_pc.
        r_pc        <= w_next_pc;
        r_state     <= StIdle;
        r_pend_kind <= PEND_BP;
        r_pend_pc   <= 32'd0;
      end else begin
        case (r_state)
          StIdle, StHeld: begin
            // Lower-priority candidates are dropped while a slot is held.
            if (w_live_wins) begin
              r_state     <= StHeld;
              r_pend_kind <= w_live_kind;
              r_pend_pc   <= w_live_pc;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign pc     = r_pc;
  assign ce     = r_ce;
  assign pend_v = (r_state == StHeld);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        new_pc;
  logic [BR_WD-1:0]   br_bus;
  logic [BR_WD-1:0]   bp_bus;
  logic [31:0]        pc;
  logic               ce;
  logic               pend_v;

  int n_cmp;
  int n_err;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_pv;
  int          m_pk;
  logic [31:0] m_pp;

  pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .new_pc (new_pc),
    .br_bus (br_bus),
    .bp_bus (bp_bus),
    .pc     (pc),
    .ce     (ce),
    .pend_v (pend_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every redirect source (live or held) gets a score; the highest score
  // wins. Live sources score 2*kind+1, the held slot 2*kind, so a live
  // source of equal kind beats the held one.
  task automatic model_step();
    int          best;
    logic [31:0] best_pc;
    logic        best_live;
    best = -1;
    best_pc = 32'd0;
    best_live = 1'b0;
    if (rst) begin
      m_pc = RST_PC - 32'd4;
      m_ce = 1'b0;
      m_pv = 1'b0;
      m_pk = 0;
      m_pp = 32'd0;
      return;
    end
    m_ce = 1'b1;
    if (m_pv && 2 * m_pk > best) begin best = 2 * m_pk; best_pc = m_pp; best_live = 1'b0; end
    if (bp_bus[32] && 1 > best) begin best = 1; best_pc = bp_bus[31:0]; best_live = 1'b1; end
    if (br_bus[32] && 3 > best) begin best = 3; best_pc = br_bus[31:0]; best_live = 1'b1; end
    if (flush && 5 > best) begin best = 5; best_pc = new_pc; best_live = 1'b1; end
    if (!stall[0]) begin
      m_pc = (best >= 0) ? best_pc : m_pc + 32'd4;
      m_pv = 1'b0;
    end else if (best_live) begin
      m_pv = 1'b1;
      m_pk = best / 2;
      m_pp = best_pc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pc", pc, m_pc);
    check("ce", {31'd0, ce}, {31'd0, m_ce});
    check("pend_v", {31'd0, pend_v}, {31'd0, m_pv});
  endtask

  task automatic quiet();
    flush  = 1'b0;
    new_pc = 32'd0;
    br_bus = '0;
    bp_bus = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_pc = 32'd0; m_ce = 1'b0; m_pv = 1'b0; m_pk = 0; m_pp = 32'd0;
    rst = 1'b1;
    stall = '0;
    quiet();

    // Reset and sequential run
    tick();
    tick();
    check("rst_pc", pc, 32'hBFBF_FFFC);
    check("rst_ce", {31'd0, ce}, 32'd0);
    check("rst_pend", {31'd0, pend_v}, 32'd0);
    rst = 1'b0;
    tick(); check("seq0", pc, 32'hBFC0_0000); check("ce_on", {31'd0, ce}, 32'd1);
    tick(); check("seq1", pc, 32'hBFC0_0004);
    tick(); check("seq2", pc, 32'hBFC0_0008);

    // Predictor hit
    bp_bus = {1'b1, 32'hBFC0_0100};
    tick(); check("bp_hit", pc, 32'hBFC0_0100);
    quiet();
    tick(); check("bp_seq", pc, 32'hBFC0_0104);

    // BR beats BP
    br_bus = {1'b1, 32'hBFC0_0200};
    bp_bus = {1'b1, 32'hBFC0_0300};
    tick(); check("br_over_bp", pc, 32'hBFC0_0200);
    quiet();

    // Redirects during a 3-cycle stall
    stall[0] = 1'b1;
    bp_bus = {1'b1, 32'hBFC0_0300};
    tick(); check("stall_hold", pc, 32'hBFC0_0200); check("held_bp", {31'd0, pend_v}, 32'd1);
    quiet(); br_bus = {1'b1, 32'hBFC0_0400};
    tick();
    quiet(); bp_bus = {1'b1, 32'hBFC0_0500};
    tick(); check("stall_hold3", pc, 32'hBFC0_0200);
    quiet(); stall[0] = 1'b0;
    tick(); check("release_br", pc, 32'hBFC0_0400); check("release_pv", {31'd0, pend_v}, 32'd0);

    // Held flush beats live BR at release
    stall[0] = 1'b1; flush = 1'b1; new_pc = 32'hBFC0_0380;
    tick();
    quiet();
    tick();
    stall[0] = 1'b0; br_bus = {1'b1, 32'hBFC0_0400};
    tick(); check("flush_over_br", pc, 32'hBFC0_0380);
    quiet();

    // Reset while held
    stall[0] = 1'b1; bp_bus = {1'b1, 32'hBFC0_0300};
    tick(); check("held_again", {31'd0, pend_v}, 32'd1);
    quiet(); rst = 1'b1;
    tick(); check("rst_held_pc", pc, 32'hBFBF_FFFC); check("rst_held_pv", {31'd0, pend_v}, 32'd0);
    rst = 1'b0; stall[0] = 1'b0;
    tick(); check("rst_rel", pc, 32'hBFC0_0000);

    // Wrap-around
    bp_bus = {1'b1, 32'hFFFF_FFFC};
    tick();
    quiet();
    tick(); check("wrap", pc, 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      stall    = STALL_W'($urandom());
      stall[0] = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      new_pc   = $urandom() & 32'hFFFF_FFFC;
      br_bus   = {($urandom_range(0, 4) == 0), $urandom() & 32'hFFFF_FFFC};
      bp_bus   = {($urandom_range(0, 3) == 0), $urandom() & 32'hFFFF_FFFC};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
